data_cache_ctrl: RTL and testbench
==================================

// Module: data_cache_ctrl
// PURPOSE
//  2-way set-associative, write-through, no-write-allocate data cache.
//  Sits between the MEM stage and the SRAM controller.
//  Serves MEM-stage loads/stores, issues 64-bit block reads and 32-bit writes to the SRAM controller.
//  Drives ready; pipeline pause = (rd_en|wr_en) & ~ready.
// PARAMETERS
//  SETS    64  number of sets (index width = log2(SETS) = 6)
//  TAG_W   10  tag width; address bits [18:9]
// PORTS
//  clk          in   1   rising-edge clock
//  rst          in   1   synchronous, active-high reset
//  address      in   32  byte address from MEM stage (ALU result); bit[2]=word, [8:3]=index, [18:9]=tag
//  wdata        in   32  store data
//  rd_en        in   1   load request; held stable until ready=1
//  wr_en        in   1   store request; held stable until ready=1
//  rdata        out  32  load data, valid when ready=1 & rd_en
//  ready        out  1   1 = request completes this cycle / no request
//  sram_address out  32  address to SRAM controller (= address)
//  sram_wdata   out  32  store data to SRAM controller (= wdata)
//  sram_rd_en   out  1   block read request (64-bit, 8-byte aligned)
//  sram_wr_en   out  1   word write request
//  sram_rdata   in   64  block from SRAM controller; [31:0]=word0, [63:32]=word1
//  sram_ready   in   1   1-cycle pulse: SRAM access done
// BEHAVIOUR
//  Storage per set: 2 ways x {valid, tag[9:0], data[63:0]}, plus 1 LRU bit (index of least-recently-used way).
//  Reset (sync): all valid=0, all LRU=0, state=IDLE. Outputs: sram_rd_en=0, sram_wr_en=0, ready=1, rdata=0.
//  Reset mid-miss/mid-write aborts the access. The SRAM request drops at that edge and no fill occurs.
//  Hit: valid & tag match in either way. Both ways never hold the same tag in one set.
//  FSM states: IDLE, RD_MISS, WRITE.
//   IDLE, wr_en=1 -> WRITE. sram_wr_en=1 from the next cycle; ready=0.
//     If the address hits, clear that way's valid bit at this edge. LRU is unchanged.
//   IDLE, rd_en=1 & hit -> stay IDLE. ready=1 combinationally, rdata = hit word, zero wait states.
//     At the edge, LRU = other way.
//   IDLE, rd_en=1 & miss -> RD_MISS; ready=0.
//   RD_MISS: sram_rd_en=1 until sram_ready.
//     On sram_ready: write {valid=1, tag, sram_rdata} into way LRU and flip LRU.
//     Same cycle: ready=1, rdata = address[2] ? sram_rdata[63:32] : sram_rdata[31:0]. Go to IDLE.
//   WRITE: sram_wr_en=1 until sram_ready. On sram_ready: ready=1, go to IDLE. The cache is not updated.
//  rd_en & wr_en both 1: the write is serviced and the read is ignored. Enables are illegal when simultaneous.
//  In IDLE with no request: ready=1, sram_* enables=0, rdata=0.
//  Latency: read hit 0 extra cycles; read miss = SRAM latency + 1; write = SRAM latency + 1.
//  Back-to-back requests: a new request may be presented the cycle after ready=1. It is evaluated from IDLE.
//  Miss fill and hit lookup use the same index. The fill is visible to the request in the next cycle.
//  Address bits [1:0] and [31:19] are ignored.
// TESTING
//  1 Reset, then rd_en @0x400 -> miss.
//    sram_rd_en=1 next cycle; sram_ready with rdata64=0x11112222_33334444 -> ready=1, rdata=0x33334444.
//  2 Then rd_en @0x404 -> hit: ready=1 same cycle, rdata=0x11112222, sram_rd_en stays 0.
//  3 Fill @0x400 (way0) and @0x600 (same set, way1).
//    Read 0x400, then read @0x800 -> miss evicts way1 (LRU).
//    Read 0x600 misses again; 0x400 still hits.
//  4 wr_en @0x400, wdata=0xDEADBEEF -> sram_wr_en=1 until sram_ready, ready=1 on that cycle.
//    Next rd @0x400 misses (line invalidated).
//  5 Assert rst while in RD_MISS -> next cycle sram_rd_en=0, ready=1.
//    A prior cached line (e.g. 0x404) now misses.
//  6 rd_en=1 & wr_en=1 @0x408 -> only sram_wr_en asserted, FSM goes to WRITE, no fill.

Source files
------------

// File: rtl/data_cache_ctrl.sv
// -----------------------------------------------------------------------------
// data_cache_ctrl
//   2-way set-associative, write-through, no-write-allocate data cache placed
//   between the MEM stage and the SRAM controller. Loads that hit complete with
//   zero wait states. Load misses fetch a 64-bit block and return the word in
//   the cycle the block arrives. Stores always go to SRAM and invalidate a
//   matching line.
//
//   Handshake: a request (rd_en or wr_en) is held stable until ready=1. The
//   request completes in the cycle where ready=1. The SRAM side is
//   level-requested (sram_rd_en / sram_wr_en) and is acknowledged by a
//   one-cycle sram_ready pulse.
//
// Ports
//   clk, rst      rising-edge clock, synchronous active-high reset
//   address       byte address: [2]=word, [8:3]=index, [18:9]=tag
//   wdata         store data
//   rd_en, wr_en  load / store request
//   rdata         load data, valid when ready=1 & rd_en
//   ready         1 = request completes this cycle, or no request pending
//   sram_address  address to the SRAM controller (pass-through)
//   sram_wdata    store data to the SRAM controller (pass-through)
//   sram_rd_en    64-bit block read request
//   sram_wr_en    32-bit word write request
//   sram_rdata    returned block, [31:0]=word0, [63:32]=word1
//   sram_ready    one-cycle pulse: SRAM access done
// -----------------------------------------------------------------------------
module data_cache_ctrl #(
    parameter int SETS  = 64,
    parameter int TAG_W = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    input  logic        rd_en,
    input  logic        wr_en,
    output logic [31:0] rdata,
    output logic        ready,
    output logic [31:0] sram_address,
    output logic [31:0] sram_wdata,
    output logic        sram_rd_en,
    output logic        sram_wr_en,
    input  logic [63:0] sram_rdata,
    input  logic        sram_ready
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_LO = 3 + IDX_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_MISS = 2'd1,
        WRITE   = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Per-set storage. Valid and LRU bits are reset; tags and data are not,
    // since they are meaningless while the valid bit is clear.
    logic [SETS-1:0]  valid0;
    logic [SETS-1:0]  valid1;
    logic [SETS-1:0]  lru;          // index of the least-recently-used way
    logic [TAG_W-1:0] tag0  [SETS];
    logic [TAG_W-1:0] tag1  [SETS];
    logic [63:0]      data0 [SETS];
    logic [63:0]      data1 [SETS];

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic             hit0;
    logic             hit1;
    logic             hit;
    logic [63:0]      hit_line;
    logic             fill;

    assign idx  = address[3 +: IDX_W];
    assign tag  = address[TAG_LO +: TAG_W];
    assign hit0 = valid0[idx] && (tag0[idx] == tag);
    assign hit1 = valid1[idx] && (tag1[idx] == tag);
    assign hit  = hit0 || hit1;
    // The two ways never hold the same tag in one set, so a plain priority
    // select is enough.
    assign hit_line = hit0 ? data0[idx] : data1[idx];
    assign fill     = (state == RD_MISS) && sram_ready;

    // Byte offset and upper address bits do not take part in the lookup.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{address[1:0], address[31:TAG_LO+TAG_W]};

    assign sram_address = address;
    assign sram_wdata   = wdata;

    // Next state and outputs. A write wins over a simultaneous read.
    always_comb begin
        state_next = state;
        ready      = 1'b1;
        rdata      = 32'd0;
        sram_rd_en = 1'b0;
        sram_wr_en = 1'b0;
        case (state)
            IDLE: begin
                if (wr_en) begin
                    ready      = 1'b0;
                    state_next = WRITE;
                end else if (rd_en) begin
                    if (hit) begin
                        rdata = address[2] ? hit_line[63:32] : hit_line[31:0];
                    end else begin
                        ready      = 1'b0;
                        state_next = RD_MISS;
                    end
                end
            end
            RD_MISS: begin
                sram_rd_en = 1'b1;
                ready      = 1'b0;
                if (sram_ready) begin
                    ready      = 1'b1;
                    rdata      = address[2] ? sram_rdata[63:32] : sram_rdata[31:0];
                    state_next = IDLE;
                end
            end
            WRITE: begin
                sram_wr_en = 1'b1;
                ready      = 1'b0;
                if (sram_ready) begin
                    ready      = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, valid and LRU bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            valid0 <= '0;
            valid1 <= '0;
            lru    <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && wr_en) begin
                // Write-through without allocate: drop the stale copy.
                if (hit0) valid0[idx] <= 1'b0;
                if (hit1) valid1[idx] <= 1'b0;
            end else if (state == IDLE && rd_en && hit) begin
                // The way not hit becomes LRU: a way-0 hit leaves way 1 as LRU.
                lru[idx] <= hit0;
            end else if (fill) begin
                if (lru[idx]) valid1[idx] <= 1'b1;
                else          valid0[idx] <= 1'b1;
                lru[idx] <= ~lru[idx];
            end
        end
    end

    // Tag and data arrays are written only on a miss fill; a reset in the
    // same cycle aborts the fill.
    always_ff @(posedge clk) begin
        if (fill && !rst) begin
            if (lru[idx]) begin
                tag1[idx]  <= tag;
                data1[idx] <= sram_rdata;
            end else begin
                tag0[idx]  <= tag;
                data0[idx] <= sram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_data_cache_ctrl.sv
// -----------------------------------------------------------------------------
// tb_data_cache_ctrl
//   Cycle-by-cycle vector table for data_cache_ctrl followed by hand-written
//   multi-cycle sequences with variable SRAM latency.
// -----------------------------------------------------------------------------
module tb_data_cache_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] address;
    logic [31:0] wdata;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] rdata;
    logic        ready;
    logic [31:0] sram_address;
    logic [31:0] sram_wdata;
    logic        sram_rd_en;
    logic        sram_wr_en;
    logic [63:0] sram_rdata;
    logic        sram_ready;

    int tests_run = 0;
    int tests_failed = 0;

    data_cache_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .address      (address),
        .wdata        (wdata),
        .rd_en        (rd_en),
        .wr_en        (wr_en),
        .rdata        (rdata),
        .ready        (ready),
        .sram_address (sram_address),
        .sram_wdata   (sram_wdata),
        .sram_rd_en   (sram_rd_en),
        .sram_wr_en   (sram_wr_en),
        .sram_rdata   (sram_rdata),
        .sram_ready   (sram_ready)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One record per clock cycle: inputs held for the cycle, expected outputs
    // sampled at the falling edge (before the commit edge).
    typedef struct {
        logic        rst;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        sr;
        logic [63:0] srd;
        logic        chk;
        logic        e_ready;
        logic [31:0] e_rdata;
        logic        e_srd;
        logic        e_swr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic rd, input logic wr,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic sr, input logic [63:0] srd,
                                input logic chk, input logic e_ready,
                                input logic [31:0] e_rdata, input logic e_srd,
                                input logic e_swr);
        vec_t v;
        v.rst = r; v.rd = rd; v.wr = wr; v.addr = a; v.wd = wd;
        v.sr = sr; v.srd = srd; v.chk = chk; v.e_ready = e_ready;
        v.e_rdata = e_rdata; v.e_srd = e_srd; v.e_swr = e_swr;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Driver tasks
    task automatic drive(input logic r, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic sr, input logic [63:0] srd);
        rst = r; rd_en = rd; wr_en = wr; address = a; wdata = wd;
        sram_ready = sr; sram_rdata = srd;
    endtask

    task automatic apply_vec(input int i, input vec_t v);
        @(posedge clk);
        #1;
        drive(v.rst, v.rd, v.wr, v.addr, v.wd, v.sr, v.srd);
        @(negedge clk);
        if (v.chk) begin
            check($sformatf("vec%0d ready", i), {63'd0, ready}, {63'd0, v.e_ready});
            check($sformatf("vec%0d rdata", i), {32'd0, rdata}, {32'd0, v.e_rdata});
            check($sformatf("vec%0d sram_rd_en", i), {63'd0, sram_rd_en}, {63'd0, v.e_srd});
            check($sformatf("vec%0d sram_wr_en", i), {63'd0, sram_wr_en}, {63'd0, v.e_swr});
            check($sformatf("vec%0d sram_address", i), {32'd0, sram_address}, {32'd0, v.addr});
            check($sformatf("vec%0d sram_wdata", i), {32'd0, sram_wdata}, {32'd0, v.wd});
        end
    endtask

    // Load miss with a given SRAM latency, then a hit on the other word.
    task automatic do_read_miss(input logic [31:0] a, input logic [63:0] d, input int lat);
        bit seen;
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b0, a, 32'd0, 1'b0, 64'd0);
        @(negedge clk);
        check("seq miss ready low", {63'd0, ready}, 64'd0);
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (sram_rd_en) seen = 1'b1;
        end
        check("seq sram_rd_en seen", {63'd0, seen}, 64'd1);
        for (int k = 1; k < lat; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("seq miss wait ready", {63'd0, ready}, 64'd0);
        end
        @(posedge clk); #1;
        sram_ready = 1'b1; sram_rdata = d;
        @(negedge clk);
        check("seq miss done ready", {63'd0, ready}, 64'd1);
        check("seq miss rdata", {32'd0, rdata}, {32'd0, (a[2] ? d[63:32] : d[31:0])});
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 64'd0);
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b0, a ^ 32'd4, 32'd0, 1'b0, 64'd0);
        @(negedge clk);
        check("seq refill hit ready", {63'd0, ready}, 64'd1);
        check("seq refill hit rdata", {32'd0, rdata}, {32'd0, (a[2] ? d[31:0] : d[63:32])});
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 64'd0);
    endtask

    // Store with a given SRAM latency.
    task automatic do_write(input logic [31:0] a, input logic [31:0] wd, input int lat);
        bit seen;
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b1, a, wd, 1'b0, 64'd0);
        @(negedge clk);
        check("seq write ready low", {63'd0, ready}, 64'd0);
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (sram_wr_en) seen = 1'b1;
        end
        check("seq sram_wr_en seen", {63'd0, seen}, 64'd1);
        for (int k = 1; k < lat; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("seq write wait ready", {63'd0, ready}, 64'd0);
            check("seq write no rd_en", {63'd0, sram_rd_en}, 64'd0);
        end
        @(posedge clk); #1;
        sram_ready = 1'b1;
        @(negedge clk);
        check("seq write done ready", {63'd0, ready}, 64'd1);
        check("seq write wdata", {32'd0, sram_wdata}, {32'd0, wd});
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 64'd0);
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 64'd0);

        //             rst  rd   wr   addr          wdata         sr   sram_rdata              chk  rdy  rdata         srd  swr
        // reset, then idle
        vecs.push_back(mk(1'b1,1'b0,1'b0,32'h0,       32'h0,        1'b0,64'h0,                   1'b0,1'b1,32'h0,        1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,       32'h0,        1'b0,64'h0,                   1'b1,1'b1,32'h0,        1'b0,1'b0));
        // read 0x400 miss, fill way0
        vecs.push_back(mk(1'b0,1'b1,1'b0,32'h400,     32'h0,        1'b0,64'h0,                   1'b1,1'b0,32'h0,        1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b0,32'h400,     32'h0,        1'b0,64'h0,                   1'b1,1'b0,32'h0,        1'b1,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b0,32'h400,     32'h0,        1'b1,64'h11112222_33334444,   1'b1,1'b1,32'h33334444, 1'b1,1'b0));
        // read 0x404 hit, zero wait
        vecs.push_back(mk(1'b0,1'b1,1'b0,32'h404,     32'h0,        1'b0,64'h0,                   1'b1,1'b1,32'h11112222, 1'b0,1'b0));
        // read 0x600 miss, fill way1
        vecs.push_back(mk(1'b0,1'b1,1'b0,32'h600,     32'h0,        1'b0,64'h0,                   1'b1,1'b0,32'h0,        1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b0,32'h600,     32'h0,        1'b0,64'h0,                   1'b1,1'b0,32'h0,        1'b1,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b0,32'h600,     32'h0,        1'b1,64'hAAAA0000_BBBB0600,   1'b1,1'b1,32'hBBBB0600, 1'b1,1'b0));
        // touch 0x400 so way1 becomes LRU
        vecs.push_back(mk(1'b0,1'b1,1'b0,32'h400,     32'h0,        1'b0,64'h0,                   1'b1,1'b1,32'h33334444, 1'b0,1'b0));
        // 0x800 misses, evicts way1 (0x600); SRAM latency of one cycle
        vecs.push_back(mk(1'b0,1'b1,1'b0,32'h800,     32'h0,        1'b0,64'h0,                   1'b1,1'b0,32'h0,        1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b0,32'h800,     32'h0,        1'b1,64'hCCCC0800_DDDD0800,   1'b1,1'b1,32'hDDDD0800, 1'b1,1'b0));
        // 0x400 still hits, 0x600 now misses
        vecs.push_back(mk(1'b0,1'b1,1'b0,32'h400,     32'h0,        1'b0,64'h0,                   1'b1,1'b1,32'h33334444, 1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b0,32'h600,     32'h0,        1'b0,64'h0,                   1'b1,1'b0,32'h0,        1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b0,32'h600,     32'h0,        1'b1,64'h06000001_06000002,   1'b1,1'b1,32'h06000002, 1'b1,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b0,32'h400,     32'h0,        1'b0,64'h0,                   1'b1,1'b1,32'h33334444, 1'b0,1'b0));
        // store 0x400 invalidates the line
        vecs.push_back(mk(1'b0,1'b0,1'b1,32'h400,     32'hDEADBEEF, 1'b0,64'h0,                   1'b1,1'b0,32'h0,        1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b1,32'h400,     32'hDEADBEEF, 1'b0,64'h0,                   1'b1,1'b0,32'h0,        1'b0,1'b1));
        vecs.push_back(mk(1'b0,1'b0,1'b1,32'h400,     32'hDEADBEEF, 1'b1,64'h0,                   1'b1,1'b1,32'h0,        1'b0,1'b1));
        vecs.push_back(mk(1'b0,1'b1,1'b0,32'h400,     32'h0,        1'b0,64'h0,                   1'b1,1'b0,32'h0,        1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b0,32'h400,     32'h0,        1'b1,64'h11112222_DEADBEEF,   1'b1,1'b1,32'hDEADBEEF, 1'b1,1'b0));
        // 0x404 hits, then reset during a miss on 0x900
        vecs.push_back(mk(1'b0,1'b1,1'b0,32'h404,     32'h0,        1'b0,64'h0,                   1'b1,1'b1,32'h11112222, 1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b0,32'h900,     32'h0,        1'b0,64'h0,                   1'b1,1'b0,32'h0,        1'b0,1'b0));
        vecs.push_back(mk(1'b1,1'b1,1'b0,32'h900,     32'h0,        1'b0,64'h0,                   1'b1,1'b0,32'h0,        1'b1,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,       32'h0,        1'b0,64'h0,                   1'b1,1'b1,32'h0,        1'b0,1'b0));
        // 0x404 lost by reset: miss, refill returns the upper word
        vecs.push_back(mk(1'b0,1'b1,1'b0,32'h404,     32'h0,        1'b0,64'h0,                   1'b1,1'b0,32'h0,        1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b0,32'h404,     32'h0,        1'b1,64'h55556666_77778888,   1'b1,1'b1,32'h55556666, 1'b1,1'b0));
        // rd & wr together: only the write runs, no fill
        vecs.push_back(mk(1'b0,1'b1,1'b1,32'h408,     32'h12345678, 1'b0,64'h0,                   1'b1,1'b0,32'h0,        1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b1,32'h408,     32'h12345678, 1'b0,64'h0,                   1'b1,1'b0,32'h0,        1'b0,1'b1));
        vecs.push_back(mk(1'b0,1'b1,1'b1,32'h408,     32'h12345678, 1'b1,64'h99999999_99999999,   1'b1,1'b1,32'h0,        1'b0,1'b1));
        vecs.push_back(mk(1'b0,1'b1,1'b0,32'h408,     32'h0,        1'b0,64'h0,                   1'b1,1'b0,32'h0,        1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b0,32'h408,     32'h0,        1'b1,64'hABCD0001_ABCD0002,   1'b1,1'b1,32'hABCD0002, 1'b1,1'b0));
        // upper and byte-offset address bits are ignored: hits line 0x400
        vecs.push_back(mk(1'b0,1'b1,1'b0,32'hFFF80405,32'h0,        1'b0,64'h0,                   1'b1,1'b1,32'h55556666, 1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,       32'h0,        1'b0,64'h0,                   1'b1,1'b1,32'h0,        1'b0,1'b0));

        foreach (vecs[i]) apply_vec(i, vecs[i]);

        // Multi-cycle latencies; the store invalidates the freshly filled line.
        do_read_miss(32'h0000_1000, 64'h0BAD_F00D_1234_5678, 3);
        do_write(32'h0000_1000, 32'hCAFEF00D, 4);
        do_read_miss(32'h0000_1004, 64'h1357_9BDF_2468_ACE0, 2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
